// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel pixel path: the window-feeder FSM state
// type, default frame geometry and the 3x3 window constants.
package sobel_pkg;

    // Window feeder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

    // Default frame geometry.
    localparam int SOBEL_IMAGE_WIDTH  = 5;
    localparam int SOBEL_IMAGE_HEIGHT = 4;
    localparam int SOBEL_PIXEL_WIDTH  = 8;

    // 3x3 kernel window.
    localparam int SOBEL_WIN_DIM  = 3;
    localparam int SOBEL_WIN_SIZE = 9;

endpackage

// File: rtl/sobel_px_skid_fifo.sv
// sobel_px_skid_fifo
// Two-entry FIFO between the frame-RAM read port and the pixel consumer.
// Each entry carries {pad, first, last, pixel}. The feeder never pushes
// into a full FIFO, so no overflow handling is needed here.
//
// Ports:
//   clk_i        clock
//   nreset_i     asynchronous active-low reset
//   push_i       write push_data_i into the tail
//   push_data_i  entry to store
//   pop_i        drop the head entry
//   head_o       head entry (meaningful when !empty_o)
//   count_o      number of stored entries, 0..2
//   empty_o      no entry stored
module sobel_px_skid_fifo #(
    parameter int DATA_W = 11
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (push_i) begin
                r_mem[r_wptr] <= push_data_i;
                r_wptr        <= ~r_wptr;
            end
            if (pop_i) begin
                r_rptr <= ~r_rptr;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;
    assign empty_o = (r_count == 2'd0);

endmodule

// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder
// Reads the grayscale frame buffer through a synchronous-read RAM port and
// streams the 9 pixels of every 3x3 window (row-major inside the window,
// windows left-to-right then top-to-bottom) to the Sobel window consumer.
// A one-cycle frame_done_o pulse follows the last accepted pixel.
//
// Build option: define SOBEL_FEEDER_BORDER_EN to centre a window on every
// pixel; taps outside the frame issue no RAM read and are emitted as 0.
//
// Ports:
//   clk_i         clock, rising edge
//   nreset_i      asynchronous active-low reset
//   start_i       start one frame (sampled in IDLE only)
//   mem_rd_o      RAM read strobe
//   mem_addr_o    RAM address, row*IMAGE_WIDTH + col
//   mem_data_i    RAM read data, valid the cycle after the read edge
//   px_o          pixel to consumer
//   px_valid_o    px_o valid
//   px_ready_i    consumer accepts (transfer on valid && ready)
//   win_first_o   px_o is pixel 0 of a window
//   win_last_o    px_o is pixel 8 of a window
//   busy_o        frame in progress
//   frame_done_o  one-cycle pulse at frame completion
module sobel_window_feeder
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH  = SOBEL_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = SOBEL_IMAGE_HEIGHT,
    parameter int PIXEL_WIDTH  = SOBEL_PIXEL_WIDTH,
    parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    output logic                   mem_rd_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [PIXEL_WIDTH-1:0] mem_data_i,
    output logic [PIXEL_WIDTH-1:0] px_o,
    output logic                   px_valid_o,
    input  logic                   px_ready_i,
    output logic                   win_first_o,
    output logic                   win_last_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    // Wide enough for the row base of the padded frame plus headroom.
    localparam int BW = $clog2((IMAGE_WIDTH + 2) * (IMAGE_HEIGHT + 2)) + 2;
    localparam int FW = PIXEL_WIDTH + 3;

`ifdef SOBEL_FEEDER_BORDER_EN
    // Column/row counters hold (window origin + 1) so they stay unsigned;
    // the address offset removes that bias plus one row.
    localparam int COL_LAST = IMAGE_WIDTH - 1;
    localparam int ROW_LAST = IMAGE_HEIGHT - 1;
    localparam int ADDR_OFF = IMAGE_WIDTH + 1;
`else
    localparam int COL_LAST = IMAGE_WIDTH - 3;
    localparam int ROW_LAST = IMAGE_HEIGHT - 3;
    localparam int ADDR_OFF = 0;
`endif

    localparam logic [CW-1:0] C_LAST  = CW'(COL_LAST);
    localparam logic [RW-1:0] R_LAST  = RW'(ROW_LAST);
    localparam logic [BW-1:0] STEP_1W = BW'(IMAGE_WIDTH);
    localparam logic [BW-1:0] STEP_2W = BW'(2 * IMAGE_WIDTH);
    localparam logic [BW-1:0] OFF     = BW'(ADDR_OFF);

    feeder_state_t   r_state;
    logic [1:0]      r_dx;
    logic [1:0]      r_dy;
    logic [CW-1:0]   r_c;
    logic [RW-1:0]   r_r;
    logic [BW-1:0]   r_row_base;   // (r + dy) * IMAGE_WIDTH, kept incrementally

    // One issued tap whose RAM data appears on mem_data_i this cycle.
    logic            r_inf_vld;
    logic            r_inf_pad;
    logic            r_inf_first;
    logic            r_inf_last;

    logic [BW-1:0]   w_col;
    logic [BW-1:0]   w_addr_full;
    logic            w_pad;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_issue;
    logic            w_tap_first;
    logic            w_tap_last;
    logic            w_frame_last;
    logic [FW-1:0]   w_head;
    logic [1:0]      w_count;
    logic            w_empty;

    assign w_col       = BW'(r_c) + BW'(r_dx);
    assign w_addr_full = r_row_base + w_col - OFF;

`ifdef SOBEL_FEEDER_BORDER_EN
    logic [BW-1:0] w_row;
    assign w_row = BW'(r_r) + BW'(r_dy);
    assign w_pad = (w_col == '0) || (w_col == BW'(IMAGE_WIDTH + 1)) ||
                   (w_row == '0) || (w_row == BW'(IMAGE_HEIGHT + 1));
`else
    assign w_pad = 1'b0;
`endif

    assign w_pop = px_valid_o && px_ready_i;

    // Items held in FIFO + in-flight after this cycle's pop; issuing only
    // when that is <= 1 keeps the total bounded by the FIFO depth.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inf_vld} - {2'b00, w_pop};
    assign w_issue = (r_state == ST_FETCH) && (w_occ <= 3'd1);

    assign w_tap_first  = (r_dx == 2'd0) && (r_dy == 2'd0);
    assign w_tap_last   = (r_dx == 2'd2) && (r_dy == 2'd2);
    assign w_frame_last = w_tap_last && (r_c == C_LAST) && (r_r == R_LAST);

    assign mem_rd_o   = w_issue && !w_pad;
    assign mem_addr_o = mem_rd_o ? ADDR_WIDTH'(w_addr_full) : '0;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state     <= ST_IDLE;
            r_dx        <= 2'd0;
            r_dy        <= 2'd0;
            r_c         <= '0;
            r_r         <= '0;
            r_row_base  <= '0;
            r_inf_vld   <= 1'b0;
            r_inf_pad   <= 1'b0;
            r_inf_first <= 1'b0;
            r_inf_last  <= 1'b0;
        end else begin
            r_inf_vld   <= w_issue;
            r_inf_pad   <= w_pad;
            r_inf_first <= w_tap_first;
            r_inf_last  <= w_tap_last;

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_FETCH;
                        r_dx       <= 2'd0;
                        r_dy       <= 2'd0;
                        r_c        <= '0;
                        r_r        <= '0;
                        r_row_base <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        if (w_frame_last) begin
                            r_state    <= ST_DRAIN;
                            r_dx       <= 2'd0;
                            r_dy       <= 2'd0;
                            r_c        <= '0;
                            r_r        <= '0;
                            r_row_base <= '0;
                        end else if (r_dx == 2'd2) begin
                            r_dx <= 2'd0;
                            if (r_dy == 2'd2) begin
                                r_dy <= 2'd0;
                                if (r_c == C_LAST) begin
                                    // Next window row: back up two rows, forward one.
                                    r_c        <= '0;
                                    r_r        <= r_r + RW'(1);
                                    r_row_base <= r_row_base - STEP_1W;
                                end else begin
                                    r_c        <= r_c + CW'(1);
                                    r_row_base <= r_row_base - STEP_2W;
                                end
                            end else begin
                                r_dy       <= r_dy + 2'd1;
                                r_row_base <= r_row_base + STEP_1W;
                            end
                        end else begin
                            r_dx <= r_dx + 2'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !r_inf_vld) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sobel_px_skid_fifo #(
        .DATA_W (FW)
    ) u_fifo (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .push_i      (r_inf_vld),
        .push_data_i ({r_inf_pad, r_inf_first, r_inf_last, mem_data_i}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .empty_o     (w_empty)
    );

    // Padded taps carry whatever was on the RAM bus; they leave as 0.
    assign px_valid_o   = !w_empty;
    assign px_o         = (px_valid_o && !w_head[FW-1]) ? w_head[PIXEL_WIDTH-1:0] : '0;
    assign win_first_o  = px_valid_o && w_head[FW-2];
    assign win_last_o   = px_valid_o && w_head[FW-3];
    assign busy_o       = (r_state != ST_IDLE);
    assign frame_done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_sobel_window_feeder.sv
module tb_sobel_window_feeder;
    import sobel_pkg::*;

    localparam int W   = 5;
    localparam int H   = 4;
    localparam int AW  = $clog2(W * H);
    localparam int W3  = 3;
    localparam int H3  = 3;
    localparam int AW3 = $clog2(W3 * H3);

`ifdef SOBEL_FEEDER_BORDER_EN
    localparam bit BORDER   = 1'b1;
    localparam int N_FRAME5 = W * H * 9;
`else
    localparam bit BORDER   = 1'b0;
    localparam int N_FRAME5 = (W - 2) * (H - 2) * 9;
`endif

    typedef struct packed {
        logic [7:0] px;
        logic       first;
        logic       last;
    } px_t;

    typedef struct {
        int  idx;
        px_t want;
    } vec_t;

    logic          clk;
    logic          nreset;
    logic          start_a, start_b;
    logic          mem_rd_a, mem_rd_b;
    logic [AW-1:0] mem_addr_a;
    logic [AW3-1:0] mem_addr_b;
    logic [7:0]    mem_data_a, mem_data_b;
    logic [7:0]    px_a, px_b;
    logic          valid_a, valid_b;
    logic          ready_a, ready_b;
    logic          first_a, first_b, last_a, last_b;
    logic          busy_a, busy_b, done_a, done_b;

    logic [7:0] ram_a [W * H];
    logic [7:0] ram_b [W3 * H3];

    sobel_window_feeder #(
        .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .PIXEL_WIDTH (8), .ADDR_WIDTH (AW)
    ) dut (
        .clk_i (clk), .nreset_i (nreset), .start_i (start_a),
        .mem_rd_o (mem_rd_a), .mem_addr_o (mem_addr_a), .mem_data_i (mem_data_a),
        .px_o (px_a), .px_valid_o (valid_a), .px_ready_i (ready_a),
        .win_first_o (first_a), .win_last_o (last_a),
        .busy_o (busy_a), .frame_done_o (done_a)
    );

    sobel_window_feeder #(
        .IMAGE_WIDTH (W3), .IMAGE_HEIGHT (H3), .PIXEL_WIDTH (8), .ADDR_WIDTH (AW3)
    ) dut3 (
        .clk_i (clk), .nreset_i (nreset), .start_i (start_b),
        .mem_rd_o (mem_rd_b), .mem_addr_o (mem_addr_b), .mem_data_i (mem_data_b),
        .px_o (px_b), .px_valid_o (valid_b), .px_ready_i (ready_b),
        .win_first_o (first_b), .win_last_o (last_b),
        .busy_o (busy_b), .frame_done_o (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read frame memories.
    always @(posedge clk) begin
        if (mem_rd_a) mem_data_a <= ram_a[mem_addr_a];
        if (mem_rd_b) mem_data_b <= ram_b[mem_addr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the windows with plain index arithmetic.
    px_t exp_q[$];
    int  exp_rd;

    function automatic void build_model(input int w, input int h, input bit sel_b);
        int lo, rmax, cmax;
        lo   = BORDER ? -1 : 0;
        rmax = h - 3 - lo;
        cmax = w - 3 - lo;
        exp_q.delete();
        exp_rd = 0;
        for (int r = lo; r <= rmax; r++) begin
            for (int c = lo; c <= cmax; c++) begin
                for (int k = 0; k < SOBEL_WIN_SIZE; k++) begin
                    int  y, x;
                    px_t e;
                    y = r + k / 3;
                    x = c + k % 3;
                    e.px = 8'd0;
                    if (x >= 0 && x < w && y >= 0 && y < h) begin
                        e.px = sel_b ? ram_b[y * w + x] : ram_a[y * w + x];
                        exp_rd++;
                    end
                    e.first = (k == 0);
                    e.last  = (k == SOBEL_WIN_SIZE - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    // Consumer-side monitors, sampled on the falling edge.
    bit  ready_mode = 1'b0;
    px_t got_a[$], got_b[$];
    int  rd_a, xfer_a, done_a_cnt, rd_b, done_b_cnt;
    int  cyc = 0, first_cyc, last_cyc, done_cyc;
    bit  prev_stall = 1'b0;
    px_t prev_word;

    always @(negedge clk) begin
        cyc++;
        if (!nreset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {valid_a, px_a, first_a, last_a}, {1'b1, prev_word});
            if (mem_rd_a) begin
                chk("rd_addr_range", (int'(mem_addr_a) < W * H), 1);
`ifndef SOBEL_FEEDER_BORDER_EN
                chk("rd_cap", ((rd_a - xfer_a - ((valid_a && ready_a) ? 1 : 0)) <= 1), 1);
`endif
                rd_a++;
            end
            if (valid_a && ready_a) begin
                got_a.push_back({px_a, first_a, last_a});
                xfer_a++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done_a) begin
                done_a_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy_a, 1);
            end
            prev_stall = valid_a && !ready_a;
            prev_word  = {px_a, first_a, last_a};

            if (mem_rd_b) rd_b++;
            if (valid_b && ready_b) got_b.push_back({px_b, first_b, last_b});
            if (done_b) done_b_cnt++;
        end
    end

    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1 ready_a = ready_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic clear_mon_a();
        got_a.delete();
        rd_a = 0; xfer_a = 0; done_a_cnt = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_rd"}, mem_rd_a, 0);
        chk({tag, "_mem_addr"}, mem_addr_a, 0);
        chk({tag, "_px"}, px_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_first"}, first_a, 0);
        chk({tag, "_last"}, last_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    task automatic compare_frame(input string tag, input px_t got[$], input int rds, input int dones);
        int n;
        chk({tag, "_xfer_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_px[%0d]", tag, i), got[i], exp_q[i]);
        chk({tag, "_rd_count"}, rds, exp_rd);
        chk({tag, "_done_pulses"}, dones, 1);
    endtask

    task automatic run_frame_a(input string tag, input bit poke, input bit lat_chk, input bit thr_chk);
        int k;
        clear_mon_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        if (lat_chk) begin
            chk({tag, "_busy_after_start"}, busy_a, 1);
`ifndef SOBEL_FEEDER_BORDER_EN
            chk({tag, "_rd_after_start"}, mem_rd_a, 1);
            chk({tag, "_addr_after_start"}, mem_addr_a, 0);
`endif
            @(posedge clk); #1 chk({tag, "_valid_e1"}, valid_a, 0);
            @(posedge clk); #1 chk({tag, "_valid_e2"}, valid_a, 1);
            chk({tag, "_head_e2"}, {px_a, first_a, last_a}, exp_q[0]);
        end
        k = 0;
        while (done_a_cnt == 0 && k < 4000) begin
            @(posedge clk); #1;
            start_a = poke && (k == 10 || k == 40);
            k++;
        end
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk({tag, "_busy_end"}, busy_a, 0);
        compare_frame(tag, got_a, rd_a, done_a_cnt);
        chk({tag, "_done_after_xfer"}, (done_cyc > last_cyc), 1);
        if (thr_chk) chk({tag, "_throughput"}, last_cyc - first_cyc, exp_q.size() - 1);
    endtask

    vec_t tbl[$];

    initial begin
        int k;
        vec_t v;
`ifdef SOBEL_FEEDER_BORDER_EN
        int bw0[9] = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
        for (int i = 0; i < 9; i++) begin
            v.idx = i; v.want.px = 8'(bw0[i]); v.want.first = (i == 0); v.want.last = (i == 8);
            tbl.push_back(v);
        end
`else
        int w0[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int w5[9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        for (int i = 0; i < 9; i++) begin
            v.idx = i; v.want.px = 8'(w0[i]); v.want.first = (i == 0); v.want.last = (i == 8);
            tbl.push_back(v);
            v.idx = 45 + i; v.want.px = 8'(w5[i]);
            tbl.push_back(v);
        end
`endif
        nreset = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_b = 1'b1;
        mem_data_a = '0; mem_data_b = '0;
        clear_mon_a();
        rd_b = 0; done_b_cnt = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(posedge clk); #1 nreset = 1'b1;

        // Basic frame, mem[a] = a, always ready.
        for (int i = 0; i < W * H; i++) ram_a[i] = 8'(i);
        build_model(W, H, 1'b0);
        ready_mode = 1'b0;
        run_frame_a("basic", 1'b0, 1'b1, 1'b1);
        chk("basic_total", got_a.size(), N_FRAME5);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].idx < got_a.size())
                chk($sformatf("table[%0d]", tbl[i].idx), got_a[tbl[i].idx], tbl[i].want);
            else
                chk("table_missing", got_a.size(), tbl[i].idx + 1);
        end

        // Backpressure with random image.
        for (int i = 0; i < W * H; i++) ram_a[i] = 8'($urandom_range(0, 255));
        build_model(W, H, 1'b0);
        ready_mode = 1'b1;
        run_frame_a("backpressure", 1'b0, 1'b0, 1'b0);

        // Start pulses mid-frame are ignored; a second start repeats the frame.
        run_frame_a("ignored_start", 1'b1, 1'b0, 1'b0);
        run_frame_a("restart", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        for (int i = 0; i < W * H; i++) ram_a[i] = 8'(i);
        build_model(W, H, 1'b0);
        ready_mode = 1'b0;
        clear_mon_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        k = 0;
        while (got_a.size() < 20 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        #1 nreset = 1'b0;
        #1 check_idle_outputs("midreset");
        chk("midreset_reached_20", (got_a.size() >= 20), 1);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        run_frame_a("after_reset", 1'b0, 1'b1, 1'b1);

        // Minimum 3x3 frame.
        for (int i = 0; i < W3 * H3; i++) ram_b[i] = 8'($urandom_range(1, 255));
        build_model(W3, H3, 1'b1);
        got_b.delete(); rd_b = 0; done_b_cnt = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        k = 0;
        while (done_b_cnt == 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1 chk("min3_busy_end", busy_b, 0);
        compare_frame("min3", got_b, rd_b, done_b_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sobel_window_feeder.md
# sobel_window_feeder

Producer side of the Sobel pixel stream. Reads the grayscale frame buffer through a synchronous-read RAM port and emits the pixels of every 3x3 window, one per handshake, in the order the Sobel window consumer loads its kernel matrix. Sits between the grayscale frame memory and the Sobel control/core. Raises a one-cycle done pulse after the last pixel of the frame is accepted.

## Interface
- IMAGE_WIDTH, 5: frame width in pixels; must be ≥ 3.
- IMAGE_HEIGHT, 4: frame height in pixels; must be ≥ 3.
- PIXEL_WIDTH, 8: grayscale pixel width.
- ADDR_WIDTH, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT): RAM address width.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- nreset_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  starts one frame; sampled only in IDLE.
- mem_rd_o  out  1  RAM read strobe.
- mem_addr_o  out  ADDR_WIDTH  RAM address, row-major (row*IMAGE_WIDTH + col).
- mem_data_i  in  PIXEL_WIDTH  RAM read data, valid the cycle after the read edge.
- px_o  out  PIXEL_WIDTH  pixel to the consumer.
- px_valid_o  out  1  px_o valid.
- px_ready_i  in  1  consumer accepts; transfer occurs when valid && ready.
- win_first_o  out  1  px_o is pixel 0 of a window.
- win_last_o  out  1  px_o is pixel 8 of a window.
- busy_o  out  1  a frame is in progress.
- frame_done_o  out  1  one-cycle pulse at frame completion.

## Operation
- Window order: window top-left (r,c), c inner 0..IMAGE_WIDTH-3, r outer 0..IMAGE_HEIGHT-3.
- In-window order: k = 3*dy + dx, k = 0..8. Address (r+dy)*IMAGE_WIDTH + (c+dx).
- Total (IMAGE_HEIGHT-2)*(IMAGE_WIDTH-2) windows, 9 pixels each.
- Address generation uses no multiplier. A row_base register is maintained incrementally by ±IMAGE_WIDTH steps.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE → FETCH on start_i. Counters are cleared.
  - FETCH → DRAIN on the edge that issues the last read of the last window.
  - DRAIN → DONE when the output FIFO is empty and no read is in flight.
  - DONE → IDLE unconditionally. frame_done_o is high for that cycle.
- start_i outside IDLE is ignored. It is not queued.
- Flow control uses a 2-entry output FIFO.
  - A read is issued only if FIFO occupancy + in-flight reads, minus a same-cycle pop, is ≤ 1.
  - Therefore the FIFO never overflows and no RAM data is dropped.
- win_first_o and win_last_o are stored alongside each pixel in the FIFO.
- Stall rule: px_o, win_first_o and win_last_o hold stable while px_valid_o && !px_ready_i.
- Counter widths: dx and dy 2 bits, c $clog2(IMAGE_WIDTH), r $clog2(IMAGE_HEIGHT). Wrap comparisons use the parameter constants.

## Timing
- Reset values: every output 0, FSM in IDLE, FIFO empty.
- Start latency:
  - start_i is sampled at edge E0.
  - mem_rd_o is high after E0; the RAM samples it at E1.
  - Data enters the FIFO at E2; px_valid_o is high after E2.
- Throughput: 1 pixel/cycle while px_ready_i is held high.
- Done timing: frame_done_o pulses the cycle after DRAIN observes empty, at least 1 cycle after the final transfer. busy_o is high from E0 through DONE.
- Reset mid-frame: returns immediately to the reset state. Outstanding RAM data is discarded. The next frame restarts at window (0,0).

## Configuration
- SOBEL_FEEDER_BORDER_EN defined:
  - Windows are centered on every pixel, giving IMAGE_HEIGHT*IMAGE_WIDTH windows; r, c range -1..dim-2.
  - Out-of-frame taps issue no RAM read. They pass through the same in-flight slot with a pad flag and are emitted as 0, so ordering is preserved.
- SOBEL_FEEDER_BORDER_EN undefined: valid-interior windows only, as described above.

## Structure
- The shared sobel package header (sobel_pkg) holds:
  - the feeder state typedef;
  - IMAGE_WIDTH/IMAGE_HEIGHT/PIXEL_WIDTH defaults;
  - the window-size constant 9.
- One sub-module, sobel_px_skid_fifo: the 2-entry FIFO carrying {pad, first, last, pixel}, with push/pop/count.

## Test plan
- Basic frame: 5x4 image, mem[a]=a, ready always high.
  - Window 0 emits 0,1,2,5,6,7,10,11,12.
  - Window 5 emits 7,8,9,12,13,14,17,18,19.
  - 54 transfers total, then frame_done_o pulses once.
- Backpressure: random px_ready_i (50%).
  - The same 54-value sequence is produced.
  - px_o is stable during every stall.
  - mem_rd_o is never issued when FIFO + in-flight = 2.
- Minimum image: 3x3 frame → exactly 9 transfers, win_first_o on pixel 0 and win_last_o on pixel 8, then done.
- Restart and ignored start: start_i pulsed mid-frame → no effect, 54 transfers. A second start in IDLE → identical frame.
- Reset mid-frame: nreset_i low after 20 transfers → all outputs 0. A new start → first window 0,1,2,5,6,7,10,11,12.
- Border mode (SOBEL_FEEDER_BORDER_EN, 5x4):
  - 180 transfers; first window 0,0,0,0,0,1,0,5,6.
  - mem_rd_o count equals the number of in-frame taps only.
